// File: rtl/blink_rate_scheduler.sv
// Shared prescaler timebase plus two rate-adjustable blinker channels and the
// registered LED output mux for the light controller.
module blink_rate_scheduler #(
   parameter int unsigned TICK_DIV   = 16,
   parameter int unsigned RATE_W     = 3,
   parameter int unsigned RATE_RESET = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              left1,
   input  logic              right1,
   input  logic              left2,
   input  logic              right2,
   input  logic [1:0]        mux_sel,
   output logic [RATE_W-1:0] rate1,
   output logic [RATE_W-1:0] rate2,
   output logic              blink1,
   output logic              blink2,
   output logic              tick,
   output logic              led
);

   localparam int unsigned       PS_W      = $clog2(TICK_DIV);
   localparam int unsigned       CNT_W     = 1 << RATE_W;
   localparam logic [PS_W-1:0]   PS_LAST   = PS_W'(TICK_DIV - 1);
   localparam logic [RATE_W-1:0] RATE_MAX  = '1;
   localparam logic [RATE_W-1:0] RATE_INIT = RATE_W'(RATE_RESET);
   localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);

   logic [PS_W-1:0] ps_cnt;
   logic [1:0]      left_in;
   logic [1:0]      right_in;

   assign left_in  = {left2, left1};
   assign right_in = {right2, right1};

   always_ff @(posedge clk) begin
      if (reset) begin
         ps_cnt <= '0;
         tick   <= 1'b0;
      end else if (ps_cnt == PS_LAST) begin
         ps_cnt <= '0;
         tick   <= 1'b1;
      end else begin
         ps_cnt <= ps_cnt + 1'b1;
         tick   <= 1'b0;
      end
   end

   for (genvar g = 0; g < 2; g++) begin : g_ch
      logic [RATE_W-1:0] rate_q;
      logic [RATE_W-1:0] rate_d;
      logic [CNT_W-1:0]  cnt_q;
      logic [CNT_W-1:0]  cnt_d;
      logic              blink_q;
      logic              blink_d;
      logic              slower;
      logic              faster;

      // A pulse that would push the rate past a bound is not a change at all.
      assign slower = right_in[g] && !left_in[g] && (rate_q != RATE_MAX);
      assign faster = left_in[g] && !right_in[g] && (rate_q != '0);

      always_comb begin
         rate_d  = rate_q;
         cnt_d   = cnt_q;
         blink_d = blink_q;
         if (slower) begin
            rate_d = rate_q + 1'b1;
            cnt_d  = '0;
         end else if (faster) begin
            rate_d = rate_q - 1'b1;
            cnt_d  = '0;
         end else if (tick) begin
            if (cnt_q == (CNT_ONE << rate_q) - CNT_ONE) begin
               cnt_d   = '0;
               blink_d = !blink_q;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
      end

      always_ff @(posedge clk) begin
         if (reset) begin
            rate_q  <= RATE_INIT;
            cnt_q   <= '0;
            blink_q <= 1'b0;
         end else begin
            rate_q  <= rate_d;
            cnt_q   <= cnt_d;
            blink_q <= blink_d;
         end
      end
   end

   assign rate1  = g_ch[0].rate_q;
   assign rate2  = g_ch[1].rate_q;
   assign blink1 = g_ch[0].blink_q;
   assign blink2 = g_ch[1].blink_q;

   always_ff @(posedge clk) begin
      if (reset) begin
         led <= 1'b0;
      end else begin
         case (mux_sel)
            2'b00:   led <= 1'b0;
            2'b01:   led <= 1'b1;
            2'b10:   led <= blink1;
            default: led <= blink2;
         endcase
      end
   end

endmodule

// File: tb/tb_blink_rate_scheduler.sv
// Scoreboard bench for blink_rate_scheduler: stimulus queues cycle-stamped
// expectations, a negedge monitor compares them against the DUT outputs.
module tb_blink_rate_scheduler;

   localparam int unsigned RATE_W = 3;

   logic              clk;
   logic              reset;
   logic              left1;
   logic              right1;
   logic              left2;
   logic              right2;
   logic [1:0]        mux_sel;
   logic [RATE_W-1:0] rate1;
   logic [RATE_W-1:0] rate2;
   logic              blink1;
   logic              blink2;
   logic              tick;
   logic              led;

   blink_rate_scheduler #(
      .TICK_DIV   (4),
      .RATE_W     (RATE_W),
      .RATE_RESET (1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .left1   (left1),
      .right1  (right1),
      .left2   (left2),
      .right2  (right2),
      .mux_sel (mux_sel),
      .rate1   (rate1),
      .rate2   (rate2),
      .blink1  (blink1),
      .blink2  (blink2),
      .tick    (tick),
      .led     (led)
   );

   typedef struct {
      int    cyc;
      int    id;
      int    val;
      string nm;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad = 0;
   int   ecount = 0;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ecount = number of rising edges seen; outputs at a negedge reflect edge ecount
   always @(posedge clk) ecount <= ecount + 1;

   function automatic int obs(input int id);
      case (id)
         0:       return int'(rate1);
         1:       return int'(rate2);
         2:       return int'(blink1);
         3:       return int'(blink2);
         4:       return int'(tick);
         default: return int'(led);
      endcase
   endfunction

   function automatic void push(input int c, input int id, input int v, input string nm);
      exp_t e;
      e.cyc = c;
      e.id  = id;
      e.val = v;
      e.nm  = nm;
      sb.push_back(e);
   endfunction

   always @(negedge clk) begin
      for (int i = sb.size() - 1; i >= 0; i--) begin
         if (sb[i].cyc == ecount) begin
            total++;
            if (obs(sb[i].id) != sb[i].val) begin
               bad++;
               $display("FAIL %s @edge %0d: got %0d want %0d", sb[i].nm, sb[i].cyc, obs(sb[i].id), sb[i].val);
            end
            sb.delete(i);
         end else if (sb[i].cyc < ecount) begin
            total++;
            bad++;
            $display("FAIL %s @edge %0d: never sampled (now %0d) want %0d", sb[i].nm, sb[i].cyc, ecount, sb[i].val);
            sb.delete(i);
         end
      end
   end

   task automatic wait_to(input int t);
      while (ecount < t) @(negedge clk);
      if (ecount > t) begin
         total++;
         bad++;
         $display("FAIL schedule: got edge %0d want %0d", ecount, t);
      end
   endtask

   // Reset is sampled on edge rr; expectations for the reset state are queued here.
   task automatic do_reset(output int rr);
      reset = 1'b1;
      rr = ecount + 1;
      push(rr, 0, 1, "rst_rate1");
      push(rr, 1, 1, "rst_rate2");
      push(rr, 2, 0, "rst_blink1");
      push(rr, 3, 0, "rst_blink2");
      push(rr, 4, 0, "rst_tick");
      push(rr, 5, 0, "rst_led");
      @(negedge clk);
      reset = 1'b0;
   endtask

   // m = {right2, left2, right1, left1}, sampled on edge e
   task automatic pulse(input int e, input logic [3:0] m);
      wait_to(e - 1);
      {right2, left2, right1, left1} = m;
      @(negedge clk);
      {right2, left2, right1, left1} = 4'b0000;
   endtask

   function automatic int b1_s5(input int j);
      return ((j - 1) / 4) % 2;
   endfunction

   function automatic int b2_s5(input int j);
      if (j < 17) return 0;
      return (((j - 17) / 16) % 2 == 0) ? 1 : 0;
   endfunction

   function automatic int sel_s5(input int k);
      if (k <= 21) return 0;
      if (k <= 25) return 1;
      if (k <= 37) return 2;
      return 3;
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: got timeout want finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int r;
      int r2;
      logic [3:0] m;
      reset = 1'b1;
      {right2, left2, right1, left1} = 4'b0000;
      mux_sel = 2'b00;
      @(negedge clk);

      // 1: free-running timebase, both channels at rate 1
      do_reset(r);
      for (int k = 1; k <= 20; k++) begin
         push(r + k, 4, (k % 4 == 0) ? 1 : 0, "s1_tick");
         push(r + k, 2, (k >= 9 && k <= 16) ? 1 : 0, "s1_blink1");
         push(r + k, 3, (k >= 9 && k <= 16) ? 1 : 0, "s1_blink2");
      end
      push(r + 12, 5, 0, "s1_led");
      wait_to(r + 21);

      // 2: saturation at both bounds; ignored pulses coincide with ticks
      do_reset(r);
      push(r + 1, 0, 0, "s2_rate1_dec");
      push(r + 10, 0, 0, "s2_rate1_floor");
      push(r + 4, 2, 0, "s2_blink1_a");
      push(r + 5, 2, 1, "s2_blink1_b");
      push(r + 8, 2, 1, "s2_blink1_c");
      push(r + 9, 2, 0, "s2_blink1_bound_tick");
      push(r + 1, 1, 2, "s2_rate2_inc");
      push(r + 10, 1, 6, "s2_rate2_mid");
      push(r + 11, 1, 7, "s2_rate2_max");
      push(r + 20, 1, 7, "s2_rate2_ceiling");
      push(r + 520, 3, 0, "s2_blink2_pre");
      push(r + 521, 3, 1, "s2_blink2_toggle");
      push(r + 522, 1, 7, "s2_rate2_end");
      for (int j = 1; j <= 19; j += 2) begin
         m = 4'b1000;
         if (j == 1 || j == 3 || j == 9) m = m | 4'b0001;
         pulse(r + j, m);
      end
      wait_to(r + 523);

      // 3: simultaneous left1/right1 on a tick and off a tick
      do_reset(r);
      push(r + 5, 0, 1, "s3_rate1_a");
      push(r + 7, 0, 1, "s3_rate1_b");
      push(r + 8, 2, 0, "s3_blink1_a");
      push(r + 9, 2, 1, "s3_blink1_b");
      push(r + 16, 2, 1, "s3_blink1_c");
      push(r + 17, 2, 0, "s3_blink1_d");
      pulse(r + 5, 4'b0011);
      pulse(r + 7, 4'b0011);
      wait_to(r + 18);

      // 4: right1 on the expiring tick: change wins, no toggle
      do_reset(r);
      push(r + 8, 0, 1, "s4_rate1_pre");
      push(r + 9, 0, 2, "s4_rate1_post");
      push(r + 9, 2, 0, "s4_blink1_no_toggle");
      push(r + 10, 2, 0, "s4_blink1_hold");
      push(r + 24, 2, 0, "s4_blink1_pre");
      push(r + 25, 2, 1, "s4_blink1_toggle");
      push(r + 9, 3, 1, "s4_blink2_indep");
      push(r + 17, 3, 0, "s4_blink2_indep2");
      pulse(r + 9, 4'b0010);
      wait_to(r + 26);

      // 5: mux sweep with rate1=0, rate2=2
      do_reset(r);
      push(r + 1, 0, 0, "s5_rate1");
      push(r + 1, 1, 2, "s5_rate2");
      push(r + 30, 2, 1, "s5_blink1");
      push(r + 30, 3, 1, "s5_blink2_a");
      push(r + 33, 3, 0, "s5_blink2_b");
      for (int k = 21; k <= 45; k++) begin
         case (sel_s5(k))
            0:       push(r + k, 5, 0, "s5_led_off");
            1:       push(r + k, 5, 1, "s5_led_on");
            2:       push(r + k, 5, b1_s5(k - 1), "s5_led_b1");
            default: push(r + k, 5, b2_s5(k - 1), "s5_led_b2");
         endcase
      end
      pulse(r + 1, 4'b1001);
      wait_to(r + 21);
      mux_sel = 2'b01;
      wait_to(r + 25);
      mux_sel = 2'b10;
      wait_to(r + 37);
      mux_sel = 2'b11;
      wait_to(r + 46);

      // 6: reset mid half-period at rate 5 with blink1 high
      mux_sel = 2'b10;
      do_reset(r);
      push(r + 7, 0, 5, "s6_rate1");
      push(r + 132, 2, 0, "s6_blink1_pre");
      push(r + 133, 2, 1, "s6_blink1_toggle");
      push(r + 133, 5, 0, "s6_led_lag");
      push(r + 134, 5, 1, "s6_led_b1");
      push(r + 148, 4, 1, "s6_tick");
      push(r + 151, 2, 1, "s6_blink1_held");
      push(r + 151, 0, 5, "s6_rate1_held");
      push(r + 151, 5, 1, "s6_led_held");
      for (int j = 1; j <= 7; j += 2) pulse(r + j, 4'b0010);
      wait_to(r + 151);
      do_reset(r2);
      push(r2 + 1, 0, 1, "s6_rate1_restart");
      push(r2 + 3, 4, 0, "s6_tick_pre");
      push(r2 + 4, 4, 1, "s6_tick_first");
      push(r2 + 8, 2, 0, "s6_blink1_pre");
      push(r2 + 9, 2, 1, "s6_blink1_first");
      push(r2 + 9, 5, 0, "s6_led_pre");
      push(r2 + 10, 5, 1, "s6_led_first");
      wait_to(r2 + 12);
      @(negedge clk);

      if (sb.size() != 0) begin
         total += sb.size();
         bad += sb.size();
         $display("FAIL leftover: got %0d unchecked want 0", sb.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/blink_rate_scheduler.md
Name: blink_rate_scheduler

Overview:
Timing engine behind the light controller's mode FSM. It owns one shared prescaler timebase and two independent blinker channels. Each channel's rate is adjusted by the single-cycle left/right shift pulses from the mode FSM. The block drives the final LED from the 2-bit mux select (off / on / blinker 1 / blinker 2).

Parameters:
TICK_DIV, 16, clock cycles per base tick (prescaler modulus, >=2; sim value, board build overrides)
RATE_W, 3, width of each channel's rate index; rate range 0..2^RATE_W-1
RATE_RESET, 3, rate index loaded into both channels at reset (must be <= 2^RATE_W-1)

Ports:
clk  input  1  system clock, all state on rising edge
reset  input  1  synchronous, active-high; returns every register to its reset value
left1  input  1  one-cycle pulse: channel 1 faster (rate1 - 1)
right1  input  1  one-cycle pulse: channel 1 slower (rate1 + 1)
left2  input  1  one-cycle pulse: channel 2 faster
right2  input  1  one-cycle pulse: channel 2 slower
mux_sel  input  2  00 off, 01 on, 10 blinker 1, 11 blinker 2
rate1  output  RATE_W  current channel 1 rate index (registered)
rate2  output  RATE_W  current channel 2 rate index (registered)
blink1  output  1  channel 1 square wave (registered)
blink2  output  1  channel 2 square wave (registered)
tick  output  1  base-tick strobe, one cycle wide (registered)
led  output  1  final LED drive (registered)

Behaviour:
- Reset values (applied on the clock edge where reset=1):
  - prescaler count 0, tick 0
  - rate1 = rate2 = RATE_RESET
  - channel counters 0
  - blink1 = blink2 = 0, led 0
- Reset overrides every other input in the same cycle. Reset mid-blink aborts the current half-period with no partial state kept.
- Prescaler:
  - counts 0..TICK_DIV-1, then wraps to 0.
  - tick is registered high for exactly one cycle each time the count wraps. First tick occurs TICK_DIV cycles after reset release; period is TICK_DIV.
- Rate update, per channel, evaluated every cycle:
  - left only: rate decrements, saturating at 0.
  - right only: rate increments, saturating at 2^RATE_W-1.
  - left and right together, or neither: no change.
  - A pulse at a bound is ignored entirely. It is not treated as a change and does not clear the counter.
  - New rate is visible on the rateN output the cycle after the pulse.
- Channel counter:
  - width 2^RATE_W bits.
  - half-period = 2^rate ticks.
  - On a tick cycle: if counter == 2^rate - 1, toggle blinkN and clear the counter; otherwise counter + 1.
  - Non-tick cycles: hold.
- Applied rate change:
  - counter cleared on the same edge that updates the rate; blinkN holds its level.
  - If an applied change coincides with a tick, the change wins: counter clears, no toggle, no increment.
- Channels are fully independent. Simultaneous pulses on both channels are both applied.
- LED:
  - led is registered from mux_sel and the current blink1/blink2 values, so it lags blinkN by one cycle.
  - Mapping: 00 gives 0, 01 gives 1, 10 gives blink1, 11 gives blink2.
  - A mux_sel change is reflected on led the next cycle.
- Channels keep running regardless of mux_sel; selecting a blinker never restarts its phase.
- No input is assumed pre-synchronised beyond single-cycle pulse width. Held-high shift inputs are not supported: each high cycle counts as one pulse.

Test Plan:
1. TICK_DIV=4, RATE_RESET=1. Reset, release, no pulses. Expected:
   - tick high on cycles 4, 8, 12 after release.
   - blink1 toggles 0->1 after the 2nd tick and 1->0 after the 4th; half-period is 8 cycles.
   - blink1 and blink2 are identical.
2. Saturation. Expected:
   - 3 left1 pulses from rate1=1: rate1 ends at 0.
   - 10 right2 pulses from 1: rate2 ends at 7.
   - Further pulses at either bound change nothing, and the counters are not cleared.
3. Simultaneous left1 and right1 in one cycle: rate1 unchanged, counter not cleared, blink1 timing unaffected.
4. right1 pulse on the same cycle as tick, with the counter one short of expiry: rate1 1->2, counter 0, no toggle. The next toggle occurs 4 ticks later.
5. mux_sel sweep 00, 01, 10, 11 with blink1 != blink2 (rate1=0, rate2=2): led equals 0, 1, blink1, blink2 with one-cycle latency at each step.
6. Reset asserted mid-half-period with rate1=5 and blink1=1: on the next edge rate1=RATE_RESET, blink1=0, led=0, tick=0. Timing restarts exactly as in scenario 1.
